// File: rtl/result_bcd_converter_pkg.sv
// Shared calculator definitions: conversion FSM states and datapath widths
// used by the ALU-result BCD converter and its interface.
package calc_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int CONV_DIGITS = 5;
    localparam int CALC_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

endpackage

// File: rtl/result_bcd_converter_if.sv
// Handshake and result bundle between the ALU-side requester and the
// BCD converter; the converter uses the slave modport.
interface result_bcd_converter_if #(
    parameter int WIDTH  = calc_pkg::CALC_WIDTH,
    parameter int DIGITS = calc_pkg::CONV_DIGITS
);
    logic                                      load;
    logic [WIDTH-1:0]                          value;
    logic                                      neg;
    logic                                      busy;
    logic                                      done;
    logic [calc_pkg::BCD_DIGIT_W*DIGITS-1:0]   bcd;
    logic                                      sign_out;
    logic [DIGITS-1:0]                         blank;

    modport master (
        output load, value, neg,
        input  busy, done, bcd, sign_out, blank
    );

    modport slave (
        input  load, value, neg,
        output busy, done, bcd, sign_out, blank
    );
endinterface

// File: rtl/result_bcd_converter_add3.sv
// Double-dabble digit corrector: a BCD digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
    import calc_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d_i,
    output logic [BCD_DIGIT_W-1:0] d_o
);

    // Conditional +3 correction
    always_comb begin
        if (d_i >= 4'd5) begin
            d_o = d_i + 4'd3;
        end else begin
            d_o = d_i;
        end
    end

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential double-dabble converter: ALU magnitude + sign -> packed BCD, one bit per clock.
// Optional leading-zero blanking is built when LEADING_ZERO_BLANK_EN is defined.
module result_bcd_converter
    import calc_pkg::*;
#(
    parameter int WIDTH  = CALC_WIDTH,
    parameter int DIGITS = CONV_DIGITS
) (
    input  logic                    clk,
    input  logic                    rst,
    result_bcd_converter_if.slave   bus
);

    localparam int SW    = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    conv_state_t       state_q,   state_d;
    logic [WIDTH-1:0]  sreg_q,    sreg_d;
    logic [SW-1:0]     scratch_q, scratch_d;
    logic [SW-1:0]     scratch_adj_s;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              neg_q,     neg_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic [SW-1:0]     bcd_q,     bcd_d;
    logic              sign_q,    sign_d;
    logic [DIGITS-1:0] blank_q,   blank_d;

`ifdef LEADING_ZERO_BLANK_EN
    // Blank every digit above the highest nonzero one; the ones digit always shows
    function automatic logic [DIGITS-1:0] lead_zero_mask(input logic [SW-1:0] b);
        logic [DIGITS-1:0] m;
        logic              seen;
        m    = {DIGITS{1'b0}};
        seen = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            seen = seen | (b[i*BCD_DIGIT_W +: BCD_DIGIT_W] != 4'd0);
            m[i] = ~seen;
        end
        return m;
    endfunction
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .d_o (scratch_adj_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Next-state and datapath logic for the conversion FSM
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        sign_d    = sign_q;
        blank_d   = blank_q;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    state_d   = LOAD;
                    sreg_d    = bus.value;
                    neg_d     = bus.neg;
                    scratch_d = {SW{1'b0}};
                    cnt_d     = {CNT_W{1'b0}};
                    busy_d    = 1'b1;
                end else begin
                    state_d   = IDLE;
                end
            end
            LOAD: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                scratch_d = {scratch_adj_s[SW-2:0], sreg_q[WIDTH-1]};
                sreg_d    = {sreg_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                bcd_d   = scratch_q;
                // A zero magnitude never shows a minus sign
                sign_d  = neg_q & (|scratch_q);
`ifdef LEADING_ZERO_BLANK_EN
                blank_d = lead_zero_mask(scratch_q);
`else
                blank_d = {DIGITS{1'b0}};
`endif
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sreg_q    <= {WIDTH{1'b0}};
            scratch_q <= {SW{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= {SW{1'b0}};
            sign_q    <= 1'b0;
            blank_q   <= {DIGITS{1'b0}};
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            sign_q    <= sign_d;
            blank_q   <= blank_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.sign_out = sign_q;
    assign bus.blank    = blank_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Scoreboard bench for result_bcd_converter: directed vectors plus a decimal-model sweep.
module tb_result_bcd_converter;

    typedef struct packed {
        logic [19:0] bcd;
        logic        sign;
        logic [4:0]  blank;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic done_prev;
    exp_t sb[$];

    result_bcd_converter_if bus ();

    result_bcd_converter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned t;
        t = v;
        r = 20'h00000;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] ref_blank(input logic [19:0] b);
        logic [4:0] m;
        m = 5'b00000;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 4; i > 0; i--) begin
            if (b[19:i*4] == 0) m[i] = 1'b1;
        end
`endif
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic start_load(input logic [15:0] v, input logic n);
        exp_t e;
        e.bcd   = ref_bcd(32'(v));
        e.sign  = n & (v != 16'd0);
        e.blank = ref_blank(e.bcd);
        sb.push_back(e);
        bus.load  = 1'b1;
        bus.value = v;
        bus.neg   = n;
        @(posedge clk);
        #1;
        bus.load  = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 40) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=%0d required=18", lat);
        end
    endtask

    task automatic do_conv(input logic [15:0] v, input logic n);
        int lat;
        start_load(v, n);
        wait_done(lat);
        chk("latency", 32'(lat), 32'd18);
    endtask

    // Monitor: pop expected result whenever the converter reports done
    always @(negedge clk) begin
        if (rst) begin
            done_prev = 1'b0;
        end else begin
            if (bus.done === 1'b1) begin
                checks++;
                if (bus.busy !== 1'b0 || done_prev !== 1'b0) begin
                    errors++;
                    $display("FAIL done_pulse busy=%b done_prev=%b required busy=0 done_prev=0",
                             bus.busy, done_prev);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done bcd=%h required no done", bus.bcd);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (bus.bcd !== e.bcd || bus.sign_out !== e.sign || bus.blank !== e.blank) begin
                        errors++;
                        $display("FAIL result actual bcd=%h sign=%b blank=%b required bcd=%h sign=%b blank=%b",
                                 bus.bcd, bus.sign_out, bus.blank, e.bcd, e.sign, e.blank);
                    end
                end
            end
            done_prev = bus.done;
        end
    end

    initial begin
        int lat;
        logic [15:0] dir_vals [8];
        checks    = 0;
        errors    = 0;
        done_prev = 1'b0;
        rst       = 1'b1;
        bus.load  = 1'b0;
        bus.value = 16'd0;
        bus.neg   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_bcd",   32'(bus.bcd),      32'd0);
        chk("reset_sign",  32'(bus.sign_out), 32'd0);
        chk("reset_blank", 32'(bus.blank),    32'd0);
        chk("reset_busy",  32'(bus.busy),     32'd0);
        chk("reset_done",  32'(bus.done),     32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // T1..T3
        do_conv(16'd0, 1'b1);
        do_conv(16'd65535, 1'b0);
        do_conv(16'd1234, 1'b1);

        // T4: load while busy is ignored, retry in the done cycle is accepted
        start_load(16'd100, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("busy_mid", 32'(bus.busy), 32'd1);
        bus.load  = 1'b1;
        bus.value = 16'd999;
        @(posedge clk);
        #1;
        bus.load  = 1'b0;
        wait_done(lat);
        do_conv(16'd999, 1'b0);

        // T5: reset mid-conversion aborts with no done
        bus.load  = 1'b1;
        bus.value = 16'd4321;
        bus.neg   = 1'b1;
        @(posedge clk);
        #1;
        bus.load  = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_bcd",   32'(bus.bcd),      32'd0);
        chk("abort_sign",  32'(bus.sign_out), 32'd0);
        chk("abort_blank", 32'(bus.blank),    32'd0);
        chk("abort_busy",  32'(bus.busy),     32'd0);
        repeat (25) @(posedge clk);
        #1;
        chk("abort_no_done_busy", 32'(bus.busy), 32'd0);
        do_conv(16'd7, 1'b0);

        // Digit-boundary values
        dir_vals = '{16'd9, 16'd10, 16'd99, 16'd100, 16'd9999, 16'd10000, 16'd59999, 16'd40960};
        foreach (dir_vals[i]) do_conv(dir_vals[i], 1'(i % 2));

        // T6: random sweep against the decimal model
        for (int k = 0; k < 1000; k++) begin
            do_conv(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
